// File: rtl/ifetch_buffer_if.sv
// Bus bundle between the fetch buffer, the instruction ROM, the redirect
// source and the decode stage.
interface ifetch_buffer_if #(
  parameter int unsigned MEM_DEPTH = 16
);
  logic [MEM_DEPTH-1:0] imem_addr;
  logic [31:0]          imem_rdata;
  logic                 redirect_valid;
  logic [MEM_DEPTH-1:0] redirect_pc;
  logic                 dec_valid;
  logic                 dec_ready;
  logic [MEM_DEPTH-1:0] dec_pc;
  logic [31:0]          dec_instr;
  logic [3:0]           fq_count;

  // Fetch buffer side
  modport master (
    output imem_addr, dec_valid, dec_pc, dec_instr, fq_count,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  // Environment side: ROM, redirect source and decode
  modport slave (
    input  imem_addr, dec_valid, dec_pc, dec_instr, fq_count,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: credit-based fetch from a synchronous ROM into a
// small FIFO feeding decode, with flush-and-restart on redirect.
module ifetch_buffer #(
  parameter int unsigned          MEM_DEPTH     = 16,
  parameter logic [MEM_DEPTH-1:0] PC_START_ADDR = '0,
  parameter int unsigned          FQ_DEPTH      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ifetch_buffer_if.master      bus
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [MEM_DEPTH-1:0] pc;
    logic [31:0]          instr;
  } fq_entry_t;

  logic [MEM_DEPTH-1:0] fetch_pc_q,   fetch_pc_d;
  logic                 pending_q,    pending_d;
  logic [MEM_DEPTH-1:0] pending_pc_q, pending_pc_d;
  logic [PTR_W-1:0]     wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0]     count_q,      count_d;
  fq_entry_t            mem_q [FQ_DEPTH];
  fq_entry_t            mem_d [FQ_DEPTH];
  logic                 dec_valid_q,  dec_valid_d;
  fq_entry_t            head_q,       head_d;

  logic issue_c;
  logic push_c;
  logic pop_c;

  // Credit check counts the in-flight read so the queue can never overflow
  always_comb begin
    issue_c = 1'b0;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    if (!bus.redirect_valid) begin
      issue_c = (SUM_W'(count_q) + SUM_W'(pending_q)) < SUM_W'(FQ_DEPTH);
      push_c  = pending_q;
      pop_c   = (count_q != '0) && bus.dec_ready;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = 1'b0;
    pending_pc_d = pending_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~MEM_DEPTH'(3);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue_c) begin
        pending_d    = 1'b1;
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + MEM_DEPTH'(4);
      end
      if (push_c) begin
        mem_d[wr_ptr_q] = '{pc: pending_pc_q, instr: bus.imem_rdata};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Decode outputs are registered from the post-update head
    dec_valid_d = (count_d != '0);
    head_d      = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= PC_START_ADDR;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dec_valid_q  <= 1'b0;
      head_q       <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dec_valid_q  <= dec_valid_d;
      head_q       <= head_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_pc    = head_q.pc;
  assign bus.dec_instr = head_q.instr;
  assign bus.fq_count  = count_q;

  // A push into a full queue means the credit accounting is broken
  assert property (@(posedge clock) disable iff (!reset)
                   !(push_c && !pop_c && (count_q == CNT_W'(FQ_DEPTH))));

endmodule

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 16, giving the instruction address width in bits.
REQ-002 The block SHALL have parameter PC_START_ADDR, default 16'h0, giving the first fetch address after reset.
REQ-003 The block SHALL have parameter FQ_DEPTH, default 4, giving the fetch-queue entry count; legal values are 2, 4 and 8.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low clears all state immediately.
REQ-006 The block SHALL have port imem_addr, output, MEM_DEPTH bits: byte address to the synchronous instruction ROM.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: ROM read data, valid one cycle after imem_addr.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: flush request and fetch restart.
REQ-009 The block SHALL have port redirect_pc, input, MEM_DEPTH bits: restart address, sampled when redirect_valid=1.
REQ-010 The block SHALL have port dec_valid, output, 1 bit: queue head holds a valid instruction.
REQ-011 The block SHALL have port dec_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 The block SHALL have port dec_pc, output, MEM_DEPTH bits: address of the head instruction.
REQ-013 The block SHALL have port dec_instr, output, 32 bits: head instruction word.
REQ-014 The block SHALL have port fq_count, output, 4 bits: current queue occupancy, 0..FQ_DEPTH.

Function
REQ-015 imem_addr SHALL equal the internal fetch_pc register at all times.
REQ-016 Issue condition: fq_count + pending < FQ_DEPTH and redirect_valid=0, where pending (1 bit) marks a ROM read in flight.
REQ-017 On an issue cycle: pending<=1, pending_pc<=fetch_pc, fetch_pc<=fetch_pc+4 modulo 2^MEM_DEPTH.
REQ-018 On a non-issue cycle without redirect: fetch_pc SHALL hold and pending<=0.
REQ-019 When pending=1 and redirect_valid=0, {pending_pc, imem_rdata} SHALL be pushed into the queue tail that cycle.
REQ-020 Latency: address issued in cycle N SHALL appear at the queue head with dec_valid=1 no earlier than cycle N+2.
REQ-021 dec_valid SHALL be 1 exactly when fq_count>0; dec_pc/dec_instr SHALL show the head entry.
REQ-022 Pop occurs when dec_valid=1 and dec_ready=1; dec_pc/dec_instr SHALL hold stable while dec_valid=1 and dec_ready=0.
REQ-023 Simultaneous push and pop SHALL leave fq_count unchanged and preserve FIFO order.
REQ-024 The credit rule of REQ-016 SHALL guarantee no push occurs when fq_count=FQ_DEPTH; a push to a full queue is a design error flagged by a simulation assertion.
REQ-025 Pop from an empty queue SHALL not occur, since dec_valid=0 gates it.
REQ-026 Redirect, which has highest priority: queue emptied (fq_count<=0), pending<=0, in-flight data discarded, fetch_pc<={redirect_pc[MEM_DEPTH-1:2],2'b00}; no issue, push or pop that cycle.
REQ-027 After redirect, dec_valid SHALL be 0 in the next cycle, and the first new instruction SHALL reach the head two cycles after the first post-redirect issue.
REQ-028 Redirect asserted on consecutive cycles SHALL leave the last redirect_pc effective.
REQ-029 Queue read/write pointers SHALL wrap modulo FQ_DEPTH.

Reset
REQ-030 While reset=0: fetch_pc=PC_START_ADDR, pending=0, pending_pc=0, pointers=0, fq_count=0, dec_valid=0, dec_pc=0, dec_instr=0, all queue storage=0.
REQ-031 Reset assertion mid-operation SHALL discard all queued and in-flight instructions asynchronously, with no partial push.
REQ-032 The first issue SHALL occur in the first rising edge after reset deasserts, at address PC_START_ADDR.

Verification
REQ-033 Reset release, dec_ready=1, ROM word k=k: dec_valid rises in cycle 2 with dec_pc=0x0000 and dec_instr=0; a sustained stream follows (pc 0x0004, 0x0008 ...), one per cycle.
REQ-034 dec_ready=0 from reset: fq_count reaches 4, imem_addr holds 0x0010, dec_pc stays 0x0000; dec_ready=1 for one cycle pops one entry and issuing resumes.
REQ-035 Redirect_pc=0x0022 with queue full: next cycle fq_count=0 and dec_valid=0, imem_addr=0x0020; a later head shows dec_pc=0x0020.
REQ-036 Redirect coincident with pending read and dec_ready=1: the stale instruction is never presented and no pop is counted.
REQ-037 Redirect_pc=0xFFFC, dec_ready=1: dec_pc sequence is 0xFFFC, 0x0000, 0x0004.
REQ-038 Reset asserted asynchronously mid-stream with fq_count=3: dec_valid=0 and fq_count=0 without waiting for a clock edge; restart at PC_START_ADDR.
